// File: rtl/time_disp_scan_if.sv
// Bus between the clock counters/testbench and the time display scanner:
// binary time in, multiplexed 7-segment drive and commit pulse out.
interface time_disp_scan_if #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
);
  logic                  en;
  logic [P_SEC_BIT-1:0]  sec;
  logic [P_MIN_BIT-1:0]  min;
  logic [P_HOUR_BIT-1:0] hour;
  logic [5:0]            an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  upd;

  modport master (output en, sec, min, hour, input an, seg, dp, upd);
  modport slave  (input en, sec, min, hour, output an, seg, dp, upd);
endinterface

// File: rtl/time_disp_scan.sv
// Snapshots binary sec/min/hour, converts to BCD by repeated subtract-by-10,
// and scans six active-low 7-segment digits so a frame never shows torn time.
module time_disp_scan #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_SCAN_DIV = 100000,
  parameter int P_SCAN_BIT = 17
) (
  input logic               clk,
  input logic               reset_all,
  time_disp_scan_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;

  state_t state, state_nx;

  logic [P_SCAN_BIT-1:0] scan_cnt;
  logic [2:0]            digit_idx;
  logic                  first_snap;
  logic                  scan_wrap, frame_wrap, trigger;

  logic [P_SEC_BIT-1:0]  rem_sec,  rem_sec_nx;
  logic [P_MIN_BIT-1:0]  rem_min,  rem_min_nx;
  logic [P_HOUR_BIT-1:0] rem_hour, rem_hour_nx;
  logic                  sec_step, min_step, hour_step, conv_done;
  logic [3:0]            tens_sec, tens_min, tens_hour;

  logic [3:0] disp_sec_ones, disp_sec_tens;
  logic [3:0] disp_min_ones, disp_min_tens;
  logic [3:0] disp_hour_ones, disp_hour_tens;
  logic [3:0] cur_digit;

  logic [5:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;
  logic       upd_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign scan_wrap  = bus.en && (scan_cnt == P_SCAN_BIT'(P_SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (digit_idx == 3'd5);
  assign trigger    = bus.en && (first_snap || frame_wrap);

  // Scan position only moves while enabled, so re-enable resumes mid-digit.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      scan_cnt   <= '0;
      digit_idx  <= 3'd0;
      first_snap <= 1'b1;
    end else if (bus.en) begin
      first_snap <= 1'b0;
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + P_SCAN_BIT'(1);
      end
    end
  end

  // Exit is judged on post-step remainders so no idle CONV cycle is wasted.
  always_comb begin
    sec_step    = rem_sec  >= P_SEC_BIT'(10);
    min_step    = rem_min  >= P_MIN_BIT'(10);
    hour_step   = rem_hour >= P_HOUR_BIT'(10);
    rem_sec_nx  = sec_step  ? rem_sec  - P_SEC_BIT'(10)  : rem_sec;
    rem_min_nx  = min_step  ? rem_min  - P_MIN_BIT'(10)  : rem_min;
    rem_hour_nx = hour_step ? rem_hour - P_HOUR_BIT'(10) : rem_hour;
    conv_done   = (rem_sec_nx  < P_SEC_BIT'(10)) &&
                  (rem_min_nx  < P_MIN_BIT'(10)) &&
                  (rem_hour_nx < P_HOUR_BIT'(10));
  end

  always_ff @(posedge clk) begin
    if (reset_all) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    upd_c    = 1'b0;
    case (state)
      IDLE:   if (trigger) state_nx = LOAD;
      LOAD:   state_nx = CONV;
      CONV:   if (conv_done) state_nx = COMMIT;
      COMMIT: begin
        upd_c    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      rem_sec        <= '0;
      rem_min        <= '0;
      rem_hour       <= '0;
      tens_sec       <= 4'd0;
      tens_min       <= 4'd0;
      tens_hour      <= 4'd0;
      disp_sec_ones  <= 4'd0;
      disp_sec_tens  <= 4'd0;
      disp_min_ones  <= 4'd0;
      disp_min_tens  <= 4'd0;
      disp_hour_ones <= 4'd0;
      disp_hour_tens <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          rem_sec   <= bus.sec;
          rem_min   <= bus.min;
          rem_hour  <= bus.hour;
          tens_sec  <= 4'd0;
          tens_min  <= 4'd0;
          tens_hour <= 4'd0;
        end
        CONV: begin
          rem_sec  <= rem_sec_nx;
          rem_min  <= rem_min_nx;
          rem_hour <= rem_hour_nx;
          if (sec_step)  tens_sec  <= tens_sec  + 4'd1;
          if (min_step)  tens_min  <= tens_min  + 4'd1;
          if (hour_step) tens_hour <= tens_hour + 4'd1;
        end
        COMMIT: begin
          disp_sec_ones  <= 4'(rem_sec);
          disp_sec_tens  <= tens_sec;
          disp_min_ones  <= 4'(rem_min);
          disp_min_tens  <= tens_min;
          disp_hour_ones <= 4'(rem_hour);
          disp_hour_tens <= tens_hour;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    case (digit_idx)
      3'd0:    cur_digit = disp_sec_ones;
      3'd1:    cur_digit = disp_sec_tens;
      3'd2:    cur_digit = disp_min_ones;
      3'd3:    cur_digit = disp_min_tens;
      3'd4:    cur_digit = disp_hour_ones;
      3'd5:    cur_digit = disp_hour_tens;
      default: cur_digit = 4'd0;
    endcase
  end

  // Colon blinks off the committed seconds parity (ones digit carries sec[0]).
  always_ff @(posedge clk) begin
    if (reset_all || !bus.en) begin
      an_r  <= 6'b111111;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= ~(6'b000001 << digit_idx);
      seg_r <= seg_decode(cur_digit);
      dp_r  <= ~(((digit_idx == 3'd2) || (digit_idx == 3'd4)) && !disp_sec_ones[0]);
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;
  assign bus.upd = upd_c;

endmodule

// File: doc/time_disp_scan.md
Name: time_disp_scan

Overview:
Reader/display end of the clock datapath. Consumes the binary sec/min/hour values produced by the clock counters and converts each to two BCD digits with a sequential subtract-by-10 engine. Drives a 6-digit, time-multiplexed, active-low 7-segment display, with snapshotting so a frame never shows torn time.

Parameters:
P_SEC_BIT, 6, width of sec input
P_MIN_BIT, 6, width of min input
P_HOUR_BIT, 5, width of hour input
P_SCAN_DIV, 100000, clk cycles each digit is displayed; legal minimum 16
P_SCAN_BIT, 17, scan counter width; must hold P_SCAN_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset_all  input  1  synchronous active-high reset
en  input  1  display enable; low blanks the display and freezes scanning
sec  input  P_SEC_BIT  binary seconds
min  input  P_MIN_BIT  binary minutes
hour  input  P_HOUR_BIT  binary hours
an  output  6  digit enables, active-low; an[0] rightmost digit
seg  output  7  segments, active-low, {g,f,e,d,c,b,a}
dp  output  1  decimal point, active-low
upd  output  1  one-cycle pulse when new BCD values are committed

Behaviour:
- Interface: one clock, clk. reset_all is synchronous and active-high.
- Reset values:
  - an=6'b111111, seg=7'h7F, dp=1, upd=0.
  - Scan counter=0, digit index=0, all BCD display registers=0, FSM=IDLE, first-snapshot flag set.
- Scan:
  - When en=1, the scan counter counts 0..P_SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→…→5→0.
  - Digit map:
    - 0 = sec ones
    - 1 = sec tens
    - 2 = min ones
    - 3 = min tens
    - 4 = hour ones
    - 5 = hour tens
- Outputs:
  - an, seg and dp are registered and reflect the digit index one cycle later.
  - an has exactly one 0 bit, at the digit index.
- dp: 0 on digits 2 and 4 when snapshot sec[0]=0 (colon blink); otherwise 1.
- Snapshot trigger: FSM IDLE→LOAD on either of:
  - the first en=1 cycle after reset, or
  - the scan wrap that moves the digit index 5→0.
- FSM states:
  - LOAD (1 cycle): capture sec/min/hour into working registers; clear tens counters.
  - CONV: each field in parallel. If remainder ≥10, subtract 10 and increment its tens, one step per cycle. Exit when all three remainders are <10.
  - COMMIT (1 cycle): copy tens/ones to the display registers, upd=1, then return to IDLE.
- Latency: trigger to upd is at most 8 cycles (LOAD + ≤6 CONV + COMMIT).
  - Digits shown during conversion use the previous committed values.
  - Inputs changing after LOAD have no effect until the next snapshot.
- Range: out-of-range inputs are converted literally.
  - sec/min up to 63 → tens 0..6.
  - hour up to 31 → tens 0..3.
  - No saturation and no error flag.
- Decoder, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- en=0:
  - an=111111 and seg=7F next cycle; dp=1.
  - Scan counter and digit index hold.
  - No new snapshot starts.
  - A conversion already in progress still completes and commits.
  - On re-enable, display resumes at the held digit and count.
- Simultaneous events:
  - A trigger while the FSM is not IDLE is dropped (unreachable when P_SCAN_DIV≥16).
  - reset_all wins over everything.
- Reset mid-conversion: FSM returns to IDLE, no upd pulse, and display registers clear to 0.

Test Plan:
1. Reset: hold reset_all 3 cycles with en=1 → an=111111, seg=7F, dp=1, upd=0; after release, upd pulses within 8 cycles.
2. P_SCAN_DIV=16; hour=23, min=59, sec=58, en=1 → upd pulse. Then an/seg sequence over one frame, each digit for 16 cycles:
   - 111110/00 (8)
   - 111101/12 (5)
   - 111011/10 (9) with dp=0
   - 110111/12 (5)
   - 101111/30 (3) with dp=0
   - 011111/24 (2)
3. Snapshot stability: after upd, change sec 58→07 while on digit 2 → digits 0/1 still show 8/5 until the 5→0 wrap; next upd within 8 cycles, then 7/0. dp=1 on digits 2/4 because sec is odd.
4. Enable: drop en mid digit 3 for 40 cycles → an=111111 next cycle and counter holds; re-raise → digit 3 resumes with the remaining count.
5. Out-of-range: sec=63, hour=31 → sec tens seg=02 (6), ones=30 (3); hour tens=30 (3), ones=79 (1); upd exactly 8 cycles after the trigger.
6. Reset mid-CONV: assert reset_all 2 cycles after LOAD with sec=59 → no upd, all outputs at reset values, display registers 0.
